// File: rtl/spart_rx_if.sv
// Receive-side bus bundle of the SPART: baud tick, serial line, read strobe and status.
interface spart_rx_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 baud_en;
   logic                 rxd;
   logic                 rx_rd;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rda;
   logic                 frame_err;
   logic                 overrun;

   modport master (
      output baud_en, rxd, rx_rd,
      input  rx_data, rda, frame_err, overrun
   );

   modport slave (
      input  baud_en, rxd, rx_rd,
      output rx_data, rda, frame_err, overrun
   );
endinterface

// File: rtl/spart_rx.sv
// SPART receive stage: oversampled 8N1 deserialiser with mid-bit sampling,
// RDA flag, frame-error and overrun status.
module spart_rx #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic      clk,
   input  logic      rst,
   spart_rx_if.slave bus
);
   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic                 sync1, sync2;
   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [BW-1:0]        bit_idx, bit_nxt;
   logic                 armed, armed_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt;
   logic                 done_c;

   // Two-flop synchroniser on the asynchronous line, idle-high at reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= bus.rxd;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         armed   <= 1'b0;
         shift   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         armed   <= armed_nxt;
         shift   <= shift_nxt;
      end
   end

   // Next-state: everything advances only on baud ticks
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      armed_nxt = armed;
      shift_nxt = shift;
      done_c    = 1'b0;
      if (bus.baud_en) begin
         case (state)
            IDLE: begin
               if (armed && !sync2) begin
                  state_nxt = START;
                  cnt_nxt   = '0;
               end else if (sync2) begin
                  armed_nxt = 1'b1;
               end
            end
            START: begin
               cnt_nxt = cnt + CW'(1);
               if (cnt == CNT_HALF) begin
                  if (sync2) begin
                     state_nxt = IDLE;
                     armed_nxt = 1'b0;
                  end else begin
                     state_nxt = DATA;
                     cnt_nxt   = '0;
                     bit_nxt   = '0;
                  end
               end
            end
            DATA: begin
               cnt_nxt = cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  shift_nxt = {sync2, shift[DATA_BITS-1:1]};
                  bit_nxt   = bit_idx + BW'(1);
                  if (bit_idx == BIT_LAST) begin
                     state_nxt = STOP;
                     cnt_nxt   = '0;
                  end
               end
            end
            STOP: begin
               cnt_nxt = cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  done_c    = 1'b1;
                  state_nxt = IDLE;
                  armed_nxt = sync2;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Status: completion wins over a simultaneous read, which then only suppresses overrun
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rx_data   <= '0;
         bus.rda       <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.overrun   <= 1'b0;
      end else if (done_c) begin
         bus.rx_data   <= shift;
         bus.rda       <= 1'b1;
         bus.frame_err <= ~sync2;
         if (bus.rda && !bus.rx_rd) bus.overrun <= 1'b1;
      end else if (bus.rx_rd && bus.rda) begin
         bus.rda     <= 1'b0;
         bus.overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: frames driven bit by bit, expected results queued
// at stimulus time and checked when the receiver reports a byte.
module tb_spart_rx;
   logic clk;
   logic rst;

   spart_rx_if #(.DATA_BITS(8)) bif ();

   spart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       fe;
      logic       ov;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-clock baud tick every fourth clock
   initial begin
      bif.baud_en = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         bif.baud_en = 1'b1;
         @(negedge clk);
         bif.baud_en = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (!bif.baud_en);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bif.rxd = 1'b1;
      ticks(n);
   endtask

   task automatic send_head(input logic [7:0] d);
      bif.rxd = 1'b0;
      ticks(16);
      for (int i = 0; i < 8; i++) begin
         bif.rxd = d[i];
         ticks(16);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      send_head(d);
      bif.rxd = stop_bit;
      ticks(16);
   endtask

   task automatic push(input logic [7:0] d, input logic fe, input logic ov);
      sb.push_back('{data: d, fe: fe, ov: ov});
   endtask

   task automatic pulse_rd();
      @(negedge clk);
      bif.rx_rd = 1'b1;
      @(negedge clk);
      bif.rx_rd = 1'b0;
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      int   n = 0;
      while (!bif.rda && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rda"}, 16'(bif.rda), 16'd1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_underflow"}, 16'(sb.size()), 16'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_data"}, 16'(bif.rx_data), 16'(e.data));
         chk({tag, "_fe"}, 16'(bif.frame_err), 16'(e.fe));
         chk({tag, "_ov"}, 16'(bif.overrun), 16'(e.ov));
      end
   endtask

   initial begin
      rst       = 1'b1;
      bif.rxd   = 1'b1;
      bif.rx_rd = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data", 16'(bif.rx_data), 16'h0);
      chk("rst_rda", 16'(bif.rda), 16'h0);
      chk("rst_fe", 16'(bif.frame_err), 16'h0);
      chk("rst_ov", 16'(bif.overrun), 16'h0);
      rst = 1'b0;
      idle(20);

      // 0xA5 with rda timing around the stop-bit sample
      push(8'hA5, 1'b0, 1'b0);
      send_head(8'hA5);
      bif.rxd = 1'b1;
      ticks(8);
      chk("a5_rda_before_stop_sample", 16'(bif.rda), 16'h0);
      ticks(1);
      chk("a5_rda_after_stop_sample", 16'(bif.rda), 16'h1);
      ticks(7);
      check_out("a5");
      pulse_rd();
      chk("a5_rd_clears_rda", 16'(bif.rda), 16'h0);

      // Quarter-bit glitch is rejected, following frame received
      bif.rxd = 1'b0;
      ticks(4);
      idle(28);
      chk("glitch_rda", 16'(bif.rda), 16'h0);
      push(8'h3C, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b1);
      idle(8);
      check_out("3c");
      pulse_rd();

      // Framing error, then break does not retrigger
      idle(16);
      push(8'h81, 1'b1, 1'b0);
      send_frame(8'h81, 1'b0);
      check_out("81");
      pulse_rd();
      ticks(480);
      chk("break_rda", 16'(bif.rda), 16'h0);
      chk("break_fe_hold", 16'(bif.frame_err), 16'h1);
      idle(32);

      // Overrun on two unread frames, single read clears both flags
      push(8'h11, 1'b0, 1'b0);
      send_frame(8'h11, 1'b1);
      idle(8);
      check_out("11");
      push(8'h22, 1'b0, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(8);
      check_out("22");
      pulse_rd();
      chk("ov_rd_rda", 16'(bif.rda), 16'h0);
      chk("ov_rd_ov", 16'(bif.overrun), 16'h0);

      // Read coinciding with completion keeps rda and suppresses overrun
      idle(8);
      push(8'h33, 1'b0, 1'b0);
      send_frame(8'h33, 1'b1);
      idle(8);
      check_out("33");
      push(8'h55, 1'b0, 1'b0);
      send_head(8'h55);
      bif.rxd = 1'b1;
      ticks(8);
      do begin
         @(negedge clk);
         #1;
      end while (!bif.baud_en);
      bif.rx_rd = 1'b1;
      @(negedge clk);
      bif.rx_rd = 1'b0;
      ticks(7);
      idle(8);
      check_out("55");

      // Reset in the middle of data bit 4 of 0xF0
      bif.rxd = 1'b0;
      ticks(16);
      for (int i = 0; i < 4; i++) begin
         bif.rxd = 1'b0;
         ticks(16);
      end
      bif.rxd = 1'b1;
      ticks(6);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_data", 16'(bif.rx_data), 16'h0);
      chk("midrst_rda", 16'(bif.rda), 16'h0);
      chk("midrst_fe", 16'(bif.frame_err), 16'h0);
      chk("midrst_ov", 16'(bif.overrun), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(20);
      push(8'h0F, 1'b0, 1'b0);
      send_frame(8'h0F, 1'b1);
      idle(8);
      check_out("0f");

      chk("sb_empty", 16'(sb.size()), 16'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
